multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencing controller for the 32-bit MIPS-subset datapath. It replaces the single-cycle combinational control path with a Moore state machine. Each instruction is stepped through fetch, decode, execute, memory and writeback over 3–5 cycles, and memory accesses are held until the unified memory acknowledges them. The block sits beside the register file, ALU and memory, and drives every mux select and write enable in the datapath.

## Interface
- CNT_W, 16, width of the retired-instruction counter

- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction[31:26] from the instruction register
- Funct  in  6  instruction[5:0]; passed through for ALU decode and not used by the FSM
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory acknowledge for the current MemRead/MemWrite
- PCWrite  out  1  PC load enable (unconditional or branch-qualified)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemToReg  out  1  writeback data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = sub, 10 = decode from Funct
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- InstrDone  out  1  one-cycle pulse in each instruction's final cycle
- Trap  out  1  sticky illegal-opcode flag
- Retired  out  CNT_W  count of completed instructions
- State  out  4  current state encoding, for debug

## Operation
- Outputs are Moore-decoded from the state, with two exceptions: MemReady gating in FETCH, and Zero gating in BRANCH. Any output not listed for a state is 0.
- IDLE: all outputs 0. Reset forces this state, and the FSM goes to FETCH on the first clock edge after release.
- FETCH
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady=0, then moves to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target goes to ALUOut). Next state by Opcode:
  - 000000 → RTYPE_EX
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) or 000101 (bne) → BRANCH
  - 001000 (addi) → ADDI_EX
  - 000010 (j) → JUMP
  - any other opcode → TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady; InstrDone=MemReady; then goes to FETCH.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemToReg=0, InstrDone=1. Goes to FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1. Goes to FETCH.
- BRANCH
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, InstrDone=1.
  - PCWrite = Zero for beq, PCWrite = ~Zero for bne.
  - Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10, InstrDone=1. Goes to FETCH.
- TRAP: Trap=1 and all other outputs 0. Absorbing state; only Reset exits it.
- Retired increments by 1 on each clock edge where InstrDone=1. It wraps modulo 2^CNT_W.

## Timing
- Reset asserted (low), asynchronously:
  - State=IDLE, Retired=0, Trap=0.
  - All other outputs are 0 within the same cycle, including mid-memory-access.
- Latency per instruction, counted from FETCH entry with MemReady tied high:
  - beq, bne, j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake: MemRead/MemWrite and the address select stay constant until the cycle in which MemReady=1 is sampled. Exactly one access completes per handshake.
- MemReady is ignored outside FETCH, MEMRD and MEMWR.
- Zero is sampled only in BRANCH.
- InstrDone is never high for two consecutive cycles.

## Test plan
- Reset, then release with MemReady=1 and Opcode=000000 → IDLE, FETCH, DECODE, RTYPE_EX, RTYPE_WB; RegWrite=1 and RegDst=1 in RTYPE_WB only; Retired=1.
- lw with MemReady low for 2 cycles in MEMRD → MemRead and IorD=1 held 3 cycles, then MEMWB with MemToReg=1; total 7 cycles.
- beq with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. beq with Zero=0 → PCWrite=0. bne with Zero=0 → PCWrite=1.
- Opcode=111111 → TRAP after DECODE; Trap=1 held for 20 cycles; RegWrite=0, MemWrite=0 and PCWrite=0 throughout; Retired unchanged.
- Reset asserted in MEMWR with MemWrite=1 → MemWrite=0 immediately; after release the next state is IDLE then FETCH; Retired=0.
- CNT_W=4: 17 back-to-back j instructions → Retired reads 1 after wrap; InstrDone pulses every 3 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback. Memory accesses hold until MemReady. Outputs are decoded from
// the state, except IRWrite/PCWrite in FETCH (gated by MemReady) and PCWrite in
// BRANCH (gated by Zero).
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             InstrDone,
  output logic             Trap,
  output logic [CNT_W-1:0] Retired,
  output logic [3:0]       State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Funct only feeds the ALU decoder beside this block.
  logic unused_funct;
  assign unused_funct = ^Funct;

  // State and retired-count registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch.
    state_d   = state_q;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSource  = 2'b00;
    InstrDone = 1'b0;
    Trap      = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target (PC+4 + imm<<2) is parked in ALUOut here.
        ALUSrcB = 2'b11;
        unique case (Opcode)
          OP_RTYPE:      state_d = S_RTYPE_EX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDI_EX;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
        if (MemReady) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        PCSource  = 2'b01;
        InstrDone = 1'b1;
        PCWrite   = (Opcode == OP_BNE) ? ~Zero : Zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        InstrDone = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: Trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Retired count advances in each instruction's final cycle, wrapping freely.
  always_comb begin
    retired_d = retired_q + CNT_W'(InstrDone);
  end

  assign Retired = retired_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of single
// instructions plus hand-written stall, trap, reset and counter-wrap sequences.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 16)
  logic        rst_n, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_write, iord, mem_read, mem_write, ir_write, reg_dst;
  logic        mem_to_reg, reg_write, alu_src_a, instr_done, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [15:0] retired;
  logic [3:0]  state;

  // Counter-wrap instance (CNT_W = 4), running back-to-back jumps
  logic        rst4_n;
  logic [5:0]  op4, funct4;
  logic        zero4, mr4;
  logic        w4_pcw, w4_iord, w4_mrd, w4_mwr, w4_irw, w4_rdst, w4_m2r, w4_rw, w4_asa;
  logic        w4_done, w4_trap;
  logic [1:0]  w4_asb, w4_aop, w4_pcs;
  logic [3:0]  w4_retired, w4_state;

  multicycle_controller u_dut (
    .Clk(clk), .Reset(rst_n), .Opcode(opcode), .Funct(funct), .Zero(zero),
    .MemReady(mem_ready), .PCWrite(pc_write), .IorD(iord), .MemRead(mem_read),
    .MemWrite(mem_write), .IRWrite(ir_write), .RegDst(reg_dst),
    .MemToReg(mem_to_reg), .RegWrite(reg_write), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ALUOp(alu_op), .PCSource(pc_source),
    .InstrDone(instr_done), .Trap(trap), .Retired(retired), .State(state)
  );

  multicycle_controller #(.CNT_W(4)) u_dut4 (
    .Clk(clk), .Reset(rst4_n), .Opcode(op4), .Funct(funct4), .Zero(zero4),
    .MemReady(mr4), .PCWrite(w4_pcw), .IorD(w4_iord), .MemRead(w4_mrd),
    .MemWrite(w4_mwr), .IRWrite(w4_irw), .RegDst(w4_rdst),
    .MemToReg(w4_m2r), .RegWrite(w4_rw), .ALUSrcA(w4_asa),
    .ALUSrcB(w4_asb), .ALUOp(w4_aop), .PCSource(w4_pcs),
    .InstrDone(w4_done), .Trap(w4_trap), .Retired(w4_retired), .State(w4_state)
  );

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5,
                         ST_MEMWR = 4'd6, ST_RTEX = 4'd7, ST_RTWB = 4'd8,
                         ST_ADDIWB = 4'd10, ST_BRANCH = 4'd11, ST_JUMP = 4'd12,
                         ST_TRAP = 4'd13;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         cycles;     // FETCH entry to final cycle, MemReady high
    logic       pcw;        // outputs expected in the final cycle
    logic [1:0] pcsrc;
    logic       regw;
    logic       regdst;
    logic       m2r;
    logic       memw;
    logic [3:0] st;
  } vec_t;

  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];       // scoreboard of expected Retired values
  int   model_retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH with MemReady high; check its final cycle.
  task automatic run_instr(input vec_t v, input int idx);
    int n;
    n = 99;
    opcode    = v.op;
    zero      = v.zero;
    mem_ready = 1'b1;
    model_retired++;
    exp_q.push_back(model_retired);
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (instr_done) begin
        n = c;
        break;
      end
      cyc();
    end
    check($sformatf("vec%0d cycles", idx), n, v.cycles);
    check($sformatf("vec%0d state", idx), state, v.st);
    check($sformatf("vec%0d PCWrite", idx), pc_write, v.pcw);
    check($sformatf("vec%0d PCSource", idx), pc_source, v.pcsrc);
    check($sformatf("vec%0d RegWrite", idx), reg_write, v.regw);
    check($sformatf("vec%0d RegDst", idx), reg_dst, v.regdst);
    check($sformatf("vec%0d MemToReg", idx), mem_to_reg, v.m2r);
    check($sformatf("vec%0d MemWrite", idx), mem_write, v.memw);
    cyc();
    check($sformatf("vec%0d back to FETCH", idx), state, ST_FETCH);
    if (exp_q.size() > 0) check($sformatf("vec%0d Retired", idx), retired, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, last, c;

    //           op          z  cyc pcw pcs   rw rd m2r mw st
    vecs[0] = '{6'b000000, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, ST_RTWB};
    vecs[1] = '{6'b001000, 1'b0, 4, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, ST_ADDIWB};
    vecs[2] = '{6'b100011, 1'b0, 5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, ST_MEMWB};
    vecs[3] = '{6'b101011, 1'b0, 4, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, ST_MEMWR};
    vecs[4] = '{6'b000100, 1'b1, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ST_BRANCH};
    vecs[5] = '{6'b000100, 1'b0, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ST_BRANCH};
    vecs[6] = '{6'b000101, 1'b0, 3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ST_BRANCH};
    vecs[7] = '{6'b000101, 1'b1, 3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, ST_BRANCH};
    vecs[8] = '{6'b000010, 1'b0, 3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, ST_JUMP};

    rst4_n = 1'b0; op4 = 6'b000010; funct4 = 6'd0; zero4 = 1'b0; mr4 = 1'b1;
    funct = 6'h2a;

    // Reset state, then an R-type walk from IDLE
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; zero = 1'b0;
    #3;
    check("reset State", state, ST_IDLE);
    check("reset Retired", retired, 0);
    check("reset Trap", trap, 0);
    check("reset MemRead", mem_read, 0);
    check("reset PCWrite", pc_write, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rt IDLE", state, ST_IDLE);
    cyc(); check("rt FETCH", state, ST_FETCH);
    check("rt IRWrite", ir_write, 1);
    check("rt fetch ALUSrcB", alu_src_b, 2'b01);
    cyc(); check("rt DECODE", state, ST_DECODE);
    check("rt decode ALUSrcB", alu_src_b, 2'b11);
    cyc(); check("rt EX", state, ST_RTEX);
    check("rt EX RegWrite", reg_write, 0);
    check("rt EX ALUOp", alu_op, 2'b10);
    cyc(); check("rt WB", state, ST_RTWB);
    check("rt WB RegWrite", reg_write, 1);
    check("rt WB RegDst", reg_dst, 1);
    cyc(); check("rt Retired", retired, 1);
    model_retired = 1;

    // Table of single instructions
    for (int i = 0; i < 9; i++) run_instr(vecs[i], i);

    // lw with MemReady low for 2 cycles in MEMRD: 7 cycles total
    opcode = 6'b100011; mem_ready = 1'b1;
    model_retired++; exp_q.push_back(model_retired);
    cyc(); check("lw DECODE", state, ST_DECODE);
    cyc(); check("lw MEMADR", state, ST_MEMADR);
    check("lw MEMADR ALUSrcB", alu_src_b, 2'b10);
    mem_ready = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) mem_ready = 1'b1;
      #1;
      check($sformatf("lw MEMRD%0d state", k), state, ST_MEMRD);
      check($sformatf("lw MEMRD%0d MemRead", k), mem_read, 1);
      check($sformatf("lw MEMRD%0d IorD", k), iord, 1);
      check($sformatf("lw MEMRD%0d InstrDone", k), instr_done, 0);
      cyc();
    end
    check("lw MEMWB state", state, ST_MEMWB);
    check("lw MEMWB MemToReg", mem_to_reg, 1);
    check("lw MEMWB InstrDone", instr_done, 1);
    cyc();
    check("lw FETCH", state, ST_FETCH);
    check("lw Retired", retired, exp_q.pop_front());

    // Illegal opcode: absorbing TRAP, no side effects
    opcode = 6'b111111;
    cyc(); check("trap DECODE", state, ST_DECODE);
    cyc();
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      #1;
      check($sformatf("trap%0d state", k), state, ST_TRAP);
      check($sformatf("trap%0d Trap", k), trap, 1);
      check($sformatf("trap%0d writes", k), {reg_write, mem_write, pc_write}, 3'b000);
      check($sformatf("trap%0d Retired", k), retired, model_retired);
      cyc();
    end

    // Reset during MEMWR: strobe drops at once, restart from IDLE
    rst_n = 1'b0; #2;
    check("trap cleared by reset", trap, 0);
    @(negedge clk); rst_n = 1'b1;
    model_retired = 0; exp_q.delete();
    cyc();
    opcode = 6'b101011; mem_ready = 1'b0; #1;
    check("sw fetch stall IRWrite", ir_write, 0);
    check("sw fetch stall PCWrite", pc_write, 0);
    cyc(); check("sw still FETCH", state, ST_FETCH);
    mem_ready = 1'b1;
    cyc(); check("sw DECODE", state, ST_DECODE);
    cyc(); mem_ready = 1'b0;
    cyc(); check("sw MEMWR", state, ST_MEMWR);
    check("sw MemWrite", mem_write, 1);
    check("sw InstrDone held", instr_done, 0);
    cyc(); check("sw MEMWR hold", state, ST_MEMWR);
    #2; rst_n = 1'b0; #1;
    check("mid-rst MemWrite", mem_write, 0);
    check("mid-rst IorD", iord, 0);
    check("mid-rst State", state, ST_IDLE);
    check("mid-rst Retired", retired, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("post-rst IDLE", state, ST_IDLE);
    cyc(); check("post-rst FETCH", state, ST_FETCH);
    check("post-rst Retired", retired, 0);

    // CNT_W=4: 17 back-to-back jumps, pulses 3 cycles apart, count wraps to 1
    @(negedge clk); rst4_n = 1'b1;
    pulses = 0; last = 0;
    for (c = 0; c < 80; c++) begin
      cyc();
      if (w4_done) begin
        if (pulses > 0) check($sformatf("j pulse gap %0d", pulses), c - last, 3);
        last = c;
        pulses++;
        if (pulses == 17) break;
      end
    end
    check("j pulse count", pulses, 17);
    cyc();
    check("j Retired wrap", w4_retired, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
